// File: rtl/imem_arbiter.sv
// Two-port arbiter for the combinational-read instruction ROM: CPU fetch has priority, debug/loader is forced after MAX_WAIT denials.
// Optional saturating performance counters are built in when IMEM_ARB_PERF_EN is defined.
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetchReq,
  input  logic [ADDR_W-1:0] i_fetchAddr,
  output logic              o_fetchGnt,
  output logic [DATA_W-1:0] o_fetchData,
  output logic              o_fetchValid,
  input  logic              i_dbgReq,
  input  logic [ADDR_W-1:0] i_dbgAddr,
  output logic              o_dbgGnt,
  output logic [DATA_W-1:0] o_dbgData,
  output logic              o_dbgValid,
  output logic              o_memCe,
  output logic [ADDR_W-1:0] o_memAddr,
  input  logic [DATA_W-1:0] i_memData
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       o_fetchCount,
  output logic [31:0]       o_dbgCount,
  output logic [31:0]       o_stallCount
`endif
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        r_starve_cnt;
  logic              r_fetch_valid;
  logic              r_dbg_valid;
  logic [DATA_W-1:0] r_fetch_data;
  logic [DATA_W-1:0] r_dbg_data;

  logic              w_force_dbg;
  logic              w_dbg_gnt;
  logic              w_fetch_gnt;
  logic              w_dbg_stall;
  logic [ADDR_W-1:0] w_mem_addr;

  always_comb begin
    w_force_dbg = i_dbgReq && (r_starve_cnt == MAX_WAIT_C);
    w_dbg_gnt   = i_dbgReq && (!i_fetchReq || w_force_dbg);
    w_fetch_gnt = i_fetchReq && !w_dbg_gnt;
    w_dbg_stall = i_dbgReq && !w_dbg_gnt;
  end

  // Address is forced to zero while idle so the ROM never sees a stale value.
  always_comb begin
    w_mem_addr = '0;
    if (w_dbg_gnt) begin
      w_mem_addr = i_dbgAddr;
    end else if (w_fetch_gnt) begin
      w_mem_addr = i_fetchAddr;
    end
  end

  assign o_fetchGnt   = w_fetch_gnt;
  assign o_dbgGnt     = w_dbg_gnt;
  assign o_memCe      = w_fetch_gnt | w_dbg_gnt;
  assign o_memAddr    = w_mem_addr;
  assign o_fetchData  = r_fetch_data;
  assign o_fetchValid = r_fetch_valid;
  assign o_dbgData    = r_dbg_data;
  assign o_dbgValid   = r_dbg_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (!i_dbgReq || w_dbg_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt < MAX_WAIT_C) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
    end else begin
      r_fetch_valid <= w_fetch_gnt;
      if (w_fetch_gnt) begin
        r_fetch_data <= i_memData;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= '0;
    end else begin
      r_dbg_valid <= w_dbg_gnt;
      if (w_dbg_gnt) begin
        r_dbg_data <= i_memData;
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_dbg_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_count <= '0;
      r_dbg_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_fetch_gnt && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_dbg_gnt && (r_dbg_count != 32'hFFFF_FFFF)) begin
        r_dbg_count <= r_dbg_count + 32'd1;
      end
      if (w_dbg_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign o_fetchCount = r_fetch_count;
  assign o_dbgCount   = r_dbg_count;
  assign o_stallCount = r_stall_count;
`endif

endmodule
